// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage RV32 pipeline, with a watchdog on the multi-cycle unit.
// Define PIPE_STALL_CNT_EN to build the saturating stall-cycle counter and its stall_cycles_o port.
module pipe_stall_ctrl #(
    parameter int MC_MAX = 64,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    input  logic             mc_start_i,
    input  logic             mc_done_i,
    input  logic             branch_taken_i,
    input  logic             load_use_i,
    output logic [4:0]       stage_en_o,
    output logic [4:0]       flush_o,
    output logic             trap_o,
    output logic [1:0]       state_o
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o
`endif
);

    localparam int CW = $clog2(MC_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(MC_MAX - 1);

    // Stage vectors are {MEM/WB, EX/MEM, ID/EX, IF/ID, PC}.
    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_MC   = 5'b11000;
    localparam logic [4:0] EN_LU   = 5'b11100;
    localparam logic [4:0] FL_TRAP = 5'b01110;
    localparam logic [4:0] FL_MC   = 5'b01000;
    localparam logic [4:0] FL_BR   = 5'b00110;
    localparam logic [4:0] FL_LU   = 5'b00100;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MC_WAIT = 2'd1,
        S_TRAP    = 2'd2
    } state_e;

    if (MC_MAX < 2) begin : g_bad_mc_max
        $error("pipe_stall_ctrl: MC_MAX must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stall_ctrl: CNT_W must be at least 1");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      en_c, flush_c;
    logic            trap_c;
    logic            mem_stall, in_wait, in_trap, mc_busy;

    assign mem_stall = dmem_req_i && !dmem_ready_i;
    assign in_wait   = (state_q == S_MC_WAIT);
    assign in_trap   = (state_q == S_TRAP);
    // The unused encoding behaves as RUN so the FSM always recovers.
    assign mc_busy   = (!in_wait && !in_trap && mc_start_i) || (in_wait && !mc_done_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_c    = '0;
        flush_c = '0;
        trap_c  = 1'b0;
        if (!mem_stall) begin
            if (in_trap) begin
                en_c    = EN_ALL;
                flush_c = FL_TRAP;
                trap_c  = 1'b1;
                state_d = S_RUN;
            end else if (mc_busy) begin
                en_c    = EN_MC;
                flush_c = FL_MC;
                if (in_wait) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_TRAP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = S_MC_WAIT;
                    cnt_d   = '0;
                end
            end else begin
                state_d = S_RUN;
                if (branch_taken_i) begin
                    en_c    = EN_ALL;
                    flush_c = FL_BR;
                end else if (load_use_i) begin
                    en_c    = EN_LU;
                    flush_c = FL_LU;
                end else begin
                    en_c    = EN_ALL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset must silence the controls immediately, not at the next edge.
    assign stage_en_o = rst ? en_c    : '0;
    assign flush_o    = rst ? flush_c : '0;
    assign trap_o     = rst && trap_c;
    assign state_o    = state_q;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!en_c[0] && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: table vectors, hand sequences and a randomized
// run against a behavioural model. Honours PIPE_STALL_CNT_EN when defined.
module tb_pipe_stall_ctrl;
    localparam int MC_MAX = 4;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic req;
        logic rdy;
        logic start;
        logic done;
        logic br;
        logic lu;
    } in_t;

    typedef struct {
        in_t        in;
        logic [12:0] exp;   // {trap, state, flush, en}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dmem_req_i = 1'b0, dmem_ready_i = 1'b0, mc_start_i = 1'b0;
    logic mc_done_i = 1'b0, branch_taken_i = 1'b0, load_use_i = 1'b0;
    logic [4:0] stage_en_o, flush_o;
    logic       trap_o;
    logic [1:0] state_o;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles_o;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [12:0] exp_q[$];
    vec_t tbl[$];

    // Behavioural model: mode 0 RUN, 1 waiting on the multi-cycle unit, 2 trap pending.
    int m_mode   = 0;
    int m_waited = 0;
    int m_stalls = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MC_MAX(MC_MAX), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .dmem_req_i     (dmem_req_i),
        .dmem_ready_i   (dmem_ready_i),
        .mc_start_i     (mc_start_i),
        .mc_done_i      (mc_done_i),
        .branch_taken_i (branch_taken_i),
        .load_use_i     (load_use_i),
        .stage_en_o     (stage_en_o),
        .flush_o        (flush_o),
        .trap_o         (trap_o),
        .state_o        (state_o)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cycles_o (stall_cycles_o)
`endif
    );

    function automatic vec_t mk(input logic [5:0] i, input logic [4:0] en, input logic [4:0] fl,
                                input logic tr, input logic [1:0] st);
        vec_t v;
        v.in  = in_t'(i);
        v.exp = {tr, st, fl, en};
        return v;
    endfunction

    function automatic logic [12:0] model_eval(input in_t i);
        logic [4:0] en;
        logic [4:0] fl;
        logic       tr;
        en = 5'b00000;
        fl = 5'b00000;
        tr = 1'b0;
        if (i.req && !i.rdy) begin
            en = 5'b00000;
        end else if (m_mode == 2) begin
            en = 5'b11111; fl = 5'b01110; tr = 1'b1;
        end else if ((m_mode == 0 && i.start) || (m_mode == 1 && !i.done)) begin
            en = 5'b11000; fl = 5'b01000;
        end else if (i.br) begin
            en = 5'b11111; fl = 5'b00110;
        end else if (i.lu) begin
            en = 5'b11100; fl = 5'b00100;
        end else begin
            en = 5'b11111;
        end
        return {tr, 2'(m_mode), fl, en};
    endfunction

    task automatic model_advance(input in_t i, input logic [12:0] e);
        if (e[0] == 1'b0 && m_stalls < (2 ** CNT_W) - 1) m_stalls++;
        if (!(i.req && !i.rdy)) begin
            case (m_mode)
                0: if (i.start) begin m_mode = 1; m_waited = 0; end
                1: begin
                    if (i.done) begin
                        m_mode = 0;
                    end else begin
                        m_waited++;
                        if (m_waited == MC_MAX) m_mode = 2;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_stalls = 0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input in_t i);
        dmem_req_i     = i.req;
        dmem_ready_i   = i.rdy;
        mc_start_i     = i.start;
        mc_done_i      = i.done;
        branch_taken_i = i.br;
        load_use_i     = i.lu;
    endtask

    task automatic run_vec(input in_t i, input logic [12:0] exp, input string name);
        logic [12:0] e;
        logic [12:0] me;
        @(posedge clk);
        #1;
        drive(i);
        exp_q.push_back(exp);
        #3;
        e = exp_q.pop_front();
        check(name, 32'({trap_o, state_o, flush_o, stage_en_o}), 32'(e));
`ifdef PIPE_STALL_CNT_EN
        check({name, "_stall_cnt"}, 32'(stall_cycles_o), 32'(m_stalls));
`endif
        me = model_eval(i);
        model_advance(i, me);
    endtask

    task automatic step(input logic [5:0] i, input logic [4:0] en, input logic [4:0] fl,
                        input logic tr, input logic [1:0] st, input string name);
        vec_t v;
        v = mk(i, en, fl, tr, st);
        run_vec(v.in, v.exp, name);
    endtask

    task automatic model_step(input in_t i, input string name);
        run_vec(i, model_eval(i), name);
    endtask

    task automatic pulse_reset(input in_t busy, input string name);
        @(posedge clk);
        #1;
        drive(busy);
        rst = 1'b0;
        #1;
        check({name, "_now"}, 32'({trap_o, state_o, flush_o, stage_en_o}), 32'd0);
`ifdef PIPE_STALL_CNT_EN
        check({name, "_cnt"}, 32'(stall_cycles_o), 32'd0);
`endif
        @(posedge clk);
        #1;
        check({name, "_held"}, 32'({trap_o, state_o, flush_o, stage_en_o}), 32'd0);
        drive(in_t'(6'b000000));
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl.push_back(mk(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b000001, 5'b11100, 5'b00100, 1'b0, 2'd0));
        tbl.push_back(mk(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b000010, 5'b11111, 5'b00110, 1'b0, 2'd0));
        tbl.push_back(mk(6'b001000, 5'b11000, 5'b01000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1));
        tbl.push_back(mk(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1));
        tbl.push_back(mk(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1));
        tbl.push_back(mk(6'b000100, 5'b11111, 5'b00000, 1'b0, 2'd1));
        tbl.push_back(mk(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b001010, 5'b11000, 5'b01000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b000110, 5'b11111, 5'b00110, 1'b0, 2'd1));
        tbl.push_back(mk(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b100001, 5'b00000, 5'b00000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b110001, 5'b11100, 5'b00100, 1'b0, 2'd0));
        tbl.push_back(mk(6'b000100, 5'b11111, 5'b00000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b001001, 5'b11000, 5'b01000, 1'b0, 2'd0));
        tbl.push_back(mk(6'b000101, 5'b11100, 5'b00100, 1'b0, 2'd1));
        tbl.push_back(mk(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0));

        // Power-on reset with busy inputs: controls must stay quiet.
        pulse_reset(in_t'(6'b001011), "por");

        foreach (tbl[k]) run_vec(tbl[k].in, tbl[k].exp, $sformatf("tbl[%0d]", k));

        // Watchdog with a memory stall in the middle: the wait count freezes.
        step(6'b001000, 5'b11000, 5'b01000, 1'b0, 2'd0, "to_start");
        step(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1, "to_w0");
        step(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1, "to_w1");
        step(6'b100000, 5'b00000, 5'b00000, 1'b0, 2'd1, "to_mem0");
        step(6'b100000, 5'b00000, 5'b00000, 1'b0, 2'd1, "to_mem1");
        step(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1, "to_w2");
        step(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1, "to_w3");
        step(6'b000000, 5'b11111, 5'b01110, 1'b1, 2'd2, "to_trap");
        step(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0, "to_after");

        // Memory stall masks done+branch in MC_WAIT until ready.
        step(6'b001000, 5'b11000, 5'b01000, 1'b0, 2'd0, "ms_start");
        step(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1, "ms_w0");
        for (int k = 0; k < 3; k++)
            step(6'b100110, 5'b00000, 5'b00000, 1'b0, 2'd1, $sformatf("ms_stall%0d", k));
        step(6'b110110, 5'b11111, 5'b00110, 1'b0, 2'd1, "ms_ready");
        step(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0, "ms_run");

        // Trap held off by a memory stall, mc_start ignored in TRAP.
        step(6'b001000, 5'b11000, 5'b01000, 1'b0, 2'd0, "th_start");
        for (int k = 0; k < MC_MAX; k++)
            step(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1, $sformatf("th_w%0d", k));
        step(6'b100000, 5'b00000, 5'b00000, 1'b0, 2'd2, "th_mem");
        step(6'b001000, 5'b11111, 5'b01110, 1'b1, 2'd2, "th_trap");
        step(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0, "th_run");

        // Reset in MC_WAIT, then a full timeout proves the wait count restarted.
        step(6'b001000, 5'b11000, 5'b01000, 1'b0, 2'd0, "rw_start");
        step(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1, "rw_w0");
        step(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1, "rw_w1");
        pulse_reset(in_t'(6'b000000), "rst_wait");
        step(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0, "rw_idle");
        step(6'b001000, 5'b11000, 5'b01000, 1'b0, 2'd0, "rw_start2");
        for (int k = 0; k < MC_MAX; k++)
            step(6'b000000, 5'b11000, 5'b01000, 1'b0, 2'd1, $sformatf("rw_w%0d", k));
        // Reset lands on the trap cycle: no trap may escape.
        pulse_reset(in_t'(6'b000000), "rst_trap");
        step(6'b000000, 5'b11111, 5'b00000, 1'b0, 2'd0, "rt_idle");

`ifdef PIPE_STALL_CNT_EN
        for (int k = 0; k < 260; k++) model_step(in_t'(6'b100000), "sat");
        model_step(in_t'(6'b000000), "sat_end");
        check("sat_value", 32'(stall_cycles_o), 32'((2 ** CNT_W) - 1));
`endif

        for (int k = 0; k < 1500; k++) begin
            in_t r;
            r.req   = ($urandom_range(0, 3) == 0);
            r.rdy   = $urandom_range(0, 1) != 0;
            r.start = ($urandom_range(0, 3) == 0);
            r.done  = ($urandom_range(0, 5) == 0);
            r.br    = ($urandom_range(0, 4) == 0);
            r.lu    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 249) == 0) pulse_reset(r, "rnd_rst");
            else model_step(r, $sformatf("rnd[%0d]", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
